pc_unit: RTL and testbench

- Program counter stage of the 8-bit nRisc datapath.
- Holds the current PC, drives it to the instruction memory address port and to the PC-increment adder's first operand.
- Selects the next PC from: sequential increment, relative branch, absolute jump, call or return.
- Provides stall and halt/resume control.

---
 rtl/pc_unit.sv | 145 ++++++++++++++
 tb/tb_pc_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter for the 8-bit nRisc datapath: next-PC select with one-cycle redirect latency, stall hold and RUN/HALT control.
// Define RET_STACK_EN to add a RS_DEPTH-entry return stack for call/ret; otherwise call acts as jump and ret as increment.
module pc_unit #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               RS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             halted,
  output logic             stack_err
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + WIDTH'(1);

`ifdef RET_STACK_EN
  localparam int PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CW = $clog2(RS_DEPTH + 1);

  logic [WIDTH-1:0] r_stack [RS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [PW-1:0]    w_top_inc;
  logic [PW-1:0]    w_top_dec;
  logic [CW-1:0]    r_count;
  logic             r_err;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;

  // Circular buffer: pushing when full lands on the oldest slot.
  assign w_top_inc = (r_top == PW'(RS_DEPTH - 1)) ? '0 : r_top + PW'(1);
  assign w_top_dec = (r_top == '0) ? PW'(RS_DEPTH - 1) : r_top - PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(RS_DEPTH));
  assign stack_err = r_err;
`else
  assign stack_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
`ifdef RET_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
`endif
    case (r_state)
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            w_state_nxt = ST_HALT;
          end else if (ret) begin
`ifdef RET_STACK_EN
            if (w_empty) begin
              w_pc_nxt  = w_pc_inc;
              w_err_set = 1'b1;
            end else begin
              w_pc_nxt = r_stack[r_top];
              w_pop    = 1'b1;
            end
`else
            w_pc_nxt = w_pc_inc;
`endif
          end else if (call) begin
`ifdef RET_STACK_EN
            w_push    = 1'b1;
            w_err_set = w_full;
`endif
            w_pc_nxt = jump_target;
          end else if (jump) begin
            w_pc_nxt = jump_target;
          end else if (branch_taken) begin
            w_pc_nxt = r_pc + branch_offset;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      ST_HALT: begin
        if (resume) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef RET_STACK_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_top   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_top <= w_top_inc;
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CW'(1);
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && w_push) r_stack[w_top_inc] <= w_pc_inc;
  end
`endif

  assign pc       = r_pc;
  assign halted   = (r_state == ST_HALT);
  assign pc_valid = reset_n && (r_state == ST_RUN) && !stall;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; stack scenarios follow RET_STACK_EN.
module tb_pc_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       jump;
  logic [7:0] jump_target;
  logic       call;
  logic       ret;
  logic       halt;
  logic       resume;
  logic [7:0] pc;
  logic       pc_valid;
  logic       halted;
  logic       stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(.WIDTH(8), .RESET_PC(8'h00), .RS_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
    .halt(halt), .resume(resume), .pc(pc), .pc_valid(pc_valid),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; branch_offset = 8'h00; jump = 0;
    jump_target = 8'h00; call = 0; ret = 0; halt = 0; resume = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;
    #1;
  endtask

  task automatic set_pc(input logic [7:0] v);
    jump = 1; jump_target = v;
    step();
    jump = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #1;
    n_checks++;
    if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_low got=%b exp=0", pc_valid); end
    step();
    n_checks++;
    if (pc !== 8'h00 || halted !== 1'b0 || stack_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_state pc=%h halted=%b err=%b exp pc=00 halted=0 err=0", pc, halted, stack_err);
    end
    reset_n = 1;
    #1;
    n_checks++;
    if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid_high got=%b exp=1", pc_valid); end
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++;
      if (pc !== 8'(i) || pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL idle_seq[%0d] pc=%h valid=%b exp pc=%h valid=1", i, pc, pc_valid, 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01;
    set_pc(8'hFE);
    n_checks++;
    if (pc !== 8'hFE) begin n_fail++; $display("FAIL wrap_start pc=%h exp=fe", pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc !== exp_seq[i]) begin n_fail++; $display("FAIL wrap[%0d] pc=%h exp=%h", i, pc, exp_seq[i]); end
    end
  endtask

  task automatic test_branch();
    set_pc(8'h10);
    branch_taken = 1; branch_offset = 8'hF8;
    step();
    n_checks++;
    if (pc !== 8'h08) begin n_fail++; $display("FAIL branch_neg pc=%h exp=08", pc); end
    jump = 1; jump_target = 8'h40;
    step();
    n_checks++;
    if (pc !== 8'h40) begin n_fail++; $display("FAIL jump_over_branch pc=%h exp=40", pc); end
    jump = 0; branch_taken = 0;
    set_pc(8'h02);
    branch_taken = 1; branch_offset = 8'hFC;
    step();
    n_checks++;
    if (pc !== 8'hFE) begin n_fail++; $display("FAIL branch_wrap pc=%h exp=fe", pc); end
    branch_offset = 8'h05;
    step();
    n_checks++;
    if (pc !== 8'h03) begin n_fail++; $display("FAIL branch_pos_wrap pc=%h exp=03", pc); end
    branch_taken = 0;
  endtask

  task automatic test_stall();
    set_pc(8'h20);
    stall = 1; jump = 1; jump_target = 8'h77;
    #1;
    n_checks++;
    if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid got=%b exp=0", pc_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc !== 8'h20 || pc_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] pc=%h valid=%b exp pc=20 valid=0", i, pc, pc_valid);
      end
    end
    stall = 0;
    step();
    n_checks++;
    if (pc !== 8'h77) begin n_fail++; $display("FAIL stall_release pc=%h exp=77", pc); end
    jump = 0;
    stall = 1; halt = 1;
    step();
    n_checks++;
    if (halted !== 1'b0 || pc !== 8'h77) begin
      n_fail++; $display("FAIL stall_blocks_halt halted=%b pc=%h exp halted=0 pc=77", halted, pc);
    end
    stall = 0; halt = 0;
  endtask

  task automatic test_halt();
    set_pc(8'h30);
    halt = 1;
    step();
    halt = 0;
    n_checks++;
    if (halted !== 1'b1 || pc !== 8'h30 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter halted=%b pc=%h valid=%b exp halted=1 pc=30 valid=0", halted, pc, pc_valid);
    end
    for (int i = 0; i < 4; i++) begin
      jump = i[0]; branch_taken = ~i[0]; branch_offset = 8'h10; jump_target = 8'h99;
      call = i[1]; ret = ~i[1];
      step();
      n_checks++;
      if (pc !== 8'h30 || halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold[%0d] pc=%h halted=%b exp pc=30 halted=1", i, pc, halted);
      end
    end
    idle_inputs();
    resume = 1;
    step();
    resume = 0;
    n_checks++;
    if (halted !== 1'b0 || pc !== 8'h30) begin
      n_fail++; $display("FAIL resume pc=%h halted=%b exp pc=30 halted=0", pc, halted);
    end
    step();
    n_checks++;
    if (pc !== 8'h31) begin n_fail++; $display("FAIL resume_inc pc=%h exp=31", pc); end
    halt = 1;
    step();
    halt = 0;
    stall = 1;
    reset_n = 0;
    step();
    n_checks++;
    if (pc !== 8'h00 || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_halt pc=%h halted=%b exp pc=00 halted=0", pc, halted);
    end
    reset_n = 1; stall = 0;
  endtask

`ifdef RET_STACK_EN
  task automatic test_ret_stack();
    logic [7:0] exp_ret [4];
    do_reset();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (pc !== 8'h05) begin n_fail++; $display("FAIL stk_start pc=%h exp=05", pc); end
    call = 1; jump_target = 8'h50;
    step();
    jump_target = 8'h60;
    step();
    call = 0;
    n_checks++;
    if (pc !== 8'h60) begin n_fail++; $display("FAIL stk_call2 pc=%h exp=60", pc); end
    ret = 1;
    step();
    n_checks++;
    if (pc !== 8'h51) begin n_fail++; $display("FAIL stk_ret1 pc=%h exp=51", pc); end
    step();
    n_checks++;
    if (pc !== 8'h06 || stack_err !== 1'b0) begin
      n_fail++; $display("FAIL stk_ret2 pc=%h err=%b exp pc=06 err=0", pc, stack_err);
    end
    step();
    ret = 0;
    n_checks++;
    if (pc !== 8'h07 || stack_err !== 1'b1) begin
      n_fail++; $display("FAIL stk_underflow pc=%h err=%b exp pc=07 err=1", pc, stack_err);
    end
    step();
    n_checks++;
    if (stack_err !== 1'b1) begin n_fail++; $display("FAIL stk_sticky err=%b exp=1", stack_err); end

    do_reset();
    n_checks++;
    if (stack_err !== 1'b0) begin n_fail++; $display("FAIL stk_err_reset err=%b exp=0", stack_err); end
    call = 1;
    for (int i = 1; i <= 4; i++) begin
      jump_target = 8'(i * 16);
      step();
    end
    n_checks++;
    if (stack_err !== 1'b0) begin n_fail++; $display("FAIL stk_full_noerr err=%b exp=0", stack_err); end
    jump_target = 8'h50;
    step();
    call = 0;
    n_checks++;
    if (pc !== 8'h50 || stack_err !== 1'b1) begin
      n_fail++; $display("FAIL stk_overflow pc=%h err=%b exp pc=50 err=1", pc, stack_err);
    end
    exp_ret[0] = 8'h41; exp_ret[1] = 8'h31; exp_ret[2] = 8'h21; exp_ret[3] = 8'h11;
    call = 1; ret = 1; jump_target = 8'h99;
    step();
    call = 0;
    n_checks++;
    if (pc !== exp_ret[0]) begin n_fail++; $display("FAIL stk_call_ret pc=%h exp=%h", pc, exp_ret[0]); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++;
      if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL stk_pop[%0d] pc=%h exp=%h", i, pc, exp_ret[i]); end
    end
    step();
    ret = 0;
    n_checks++;
    if (pc !== 8'h12) begin n_fail++; $display("FAIL stk_oldest_lost pc=%h exp=12", pc); end
  endtask
`else
  task automatic test_no_stack();
    do_reset();
    set_pc(8'h05);
    call = 1; jump_target = 8'h50;
    step();
    call = 0;
    n_checks++;
    if (pc !== 8'h50) begin n_fail++; $display("FAIL nostk_call pc=%h exp=50", pc); end
    ret = 1;
    step();
    n_checks++;
    if (pc !== 8'h51 || stack_err !== 1'b0) begin
      n_fail++; $display("FAIL nostk_ret pc=%h err=%b exp pc=51 err=0", pc, stack_err);
    end
    call = 1; jump_target = 8'h99;
    step();
    call = 0; ret = 0;
    n_checks++;
    if (pc !== 8'h52 || stack_err !== 1'b0) begin
      n_fail++; $display("FAIL nostk_call_ret pc=%h err=%b exp pc=52 err=0", pc, stack_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_stall();
    test_halt();
`ifdef RET_STACK_EN
    test_ret_stack();
`else
    test_no_stack();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
